// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter, LSB first, gapless back-to-back frames
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = CLK_PER_BIT > 1 ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          push, pop, bit_end;
  assign in_ready   = cnt_q != (AW+1)'(FIFO_DEPTH);
  assign push       = in_valid && in_ready;
  assign bit_end    = cyc_q == CW'(CLK_PER_BIT - 1);
  assign pop        = (state_q == IDLE || (state_q == STOP && bit_end)) && cnt_q != '0;
  assign cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign fifo_count = cnt_q;
  assign busy       = state_q != IDLE || cnt_q != '0;
  assign txd        = txd_q;
  // Bit-timing FSM: a pop always restarts a frame, otherwise advance on bit boundaries
  always_comb begin
    state_d = state_q;
    cyc_d   = (state_q == IDLE || bit_end) ? '0 : cyc_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    if (pop) begin
      state_d = START;
      sh_d    = mem_q[rp_q];
      txd_d   = 1'b0;
    end else if (bit_end && state_q == START) begin
      state_d = DATA;
      bit_d   = '0;
      txd_d   = sh_q[0];
    end else if (bit_end && state_q == DATA) begin
      state_d = bit_q == 3'd7 ? STOP : DATA;
      bit_d   = bit_q + 1'b1;
      sh_d    = sh_q >> 1;
      txd_d   = bit_q == 3'd7 ? 1'b1 : sh_q[1];
    end else if (bit_end && state_q == STOP) begin
      state_d = IDLE;
      txd_d   = 1'b1;
    end
  end
  // FIFO storage is not reset; occupancy and pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_data;
  end
  // State, counters, pointers and the registered line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      wp_q    <= push ? wp_q + 1'b1 : wp_q;
      rp_q    <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed, table-driven and model-checked random tests of uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int D   = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       va = 1'b0, vb = 1'b0;
  logic [7:0] da = '0, db = '0;
  logic       ra, rb, ba, bb, tx_a, tx_b;
  logic [2:0] ca, cb;
  int         total = 0;
  int         bad = 0;
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] cnt;
    logic       rdy;
  } vec_t;
  vec_t tbl [8];

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(D)) dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_data(da),
    .in_ready(ra), .fifo_count(ca), .busy(ba), .txd(tx_a));
  uart_tx_fifo #(.CLK_PER_BIT(1), .FIFO_DEPTH(D)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_data(db),
    .in_ready(rb), .fifo_count(cb), .busy(bb), .txd(tx_b));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    va = 1'b0;
    vb = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic [159:0] wave(input logic [7:0] b0, input logic [7:0] b1,
                                        input int nf, input int cpb);
    logic [19:0]  f = {frame(b1), frame(b0)};
    logic [159:0] r = '0;
    for (int i = 0; i < nf * 10 * cpb; i++) r[i] = f[i / cpb];
    return r;
  endfunction

  task automatic capture(input bit sel_b, input int n, output logic [159:0] cap);
    cap = '0;
    cap[0] = sel_b ? tx_b : tx_a;
    for (int i = 1; i < n; i++) begin
      tick();
      cap[i] = sel_b ? tx_b : tx_a;
    end
  endtask

  task automatic rx(output logic [7:0] b, output bit ok);
    b = '0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!tx_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    repeat (CPB / 2) tick();
    ok = !tx_a;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = tx_a;
    end
    repeat (CPB) tick();
    ok = ok && tx_a;
  endtask

  initial begin
    logic [159:0] cap;
    logic [7:0]   q [$];
    logic [7:0]   cur, b;
    logic [9:0]   fr;
    logic         act, acc, exp_txd;
    bit           ok;
    int           t, pct;
    for (int i = 0; i < 8; i++) begin
      tbl[i].v = 1'b1;
      tbl[i].d = 8'(i + 1);
    end
    tbl[0].cnt = 3'd1; tbl[0].rdy = 1'b1;
    tbl[1].cnt = 3'd1; tbl[1].rdy = 1'b1;
    tbl[2].cnt = 3'd2; tbl[2].rdy = 1'b1;
    tbl[3].cnt = 3'd3; tbl[3].rdy = 1'b1;
    tbl[4].cnt = 3'd4; tbl[4].rdy = 1'b0;
    tbl[5].cnt = 3'd4; tbl[5].rdy = 1'b0;
    tbl[6].cnt = 3'd4; tbl[6].rdy = 1'b0;
    tbl[7].cnt = 3'd4; tbl[7].rdy = 1'b0;

    // 1: reset held with in_valid high
    va = 1'b1; da = 8'hAA; vb = 1'b1; db = 8'h55;
    tick();
    tick();
    chk("rst_txd", tx_a, 1'b1);
    chk("rst_ready", ra, 1'b1);
    chk("rst_busy", ba, 1'b0);
    chk("rst_count", ca, 3'd0);
    chk("rst_count_b", cb, 3'd0);
    va = 1'b0; vb = 1'b0; reset = 1'b0;
    tick();
    chk("post_rst_idle", {tx_a, ba, ca}, {1'b1, 1'b0, 3'd0});

    // 2: single frame 0x55
    va = 1'b1; da = 8'h55;
    tick();
    va = 1'b0;
    chk("push_count", ca, 3'd1);
    tick();
    capture(1'b0, 40, cap);
    chk("frame_55", cap, wave(8'h55, 8'h00, 1, CPB));
    chk("busy_e40", ba, 1'b1);
    tick();
    chk("busy_e41", ba, 1'b0);

    // 3: two queued frames, no gap
    do_reset();
    va = 1'b1; da = 8'hA5;
    tick();
    da = 8'h3C;
    tick();
    va = 1'b0;
    capture(1'b0, 80, cap);
    chk("frames_a5_3c", cap, wave(8'hA5, 8'h3C, 2, CPB));
    chk("busy_e80", ba, 1'b1);
    tick();
    chk("busy_e81", ba, 1'b0);

    // 4: overfill, table of pushes alongside a line decoder
    do_reset();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          va = tbl[i].v;
          da = tbl[i].d;
          tick();
          chk($sformatf("fill_cnt%0d", i), ca, tbl[i].cnt);
          chk($sformatf("fill_rdy%0d", i), ra, tbl[i].rdy);
        end
        va = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          rx(b, ok);
          chk($sformatf("rx_ok%0d", k), ok, 1'b1);
          chk($sformatf("rx_byte%0d", k), b, 8'(k + 1));
        end
      end
    join
    repeat (10) tick();
    chk("fill_drained", {tx_a, ba, ca}, {1'b1, 1'b0, 3'd0});

    // 5: reset during DATA bit 3, queued byte discarded
    do_reset();
    va = 1'b1; da = 8'hFF;
    tick();
    da = 8'h12;
    tick();
    va = 1'b0;
    repeat (17) tick();
    chk("bit3_txd", {tx_a, ba, ca}, {1'b1, 1'b1, 3'd1});
    reset = 1'b1;
    #1;
    chk("async_rst", {tx_a, ra, ba, ca}, {1'b1, 1'b1, 1'b0, 3'd0});
    tick();
    reset = 1'b0;
    tick();
    chk("rst_release", {tx_a, ba, ca}, {1'b1, 1'b0, 3'd0});
    va = 1'b1; da = 8'h00;
    tick();
    va = 1'b0;
    tick();
    capture(1'b0, 40, cap);
    chk("frame_00", cap, wave(8'h00, 8'h00, 1, CPB));
    tick();
    chk("after_00", {tx_a, ba}, {1'b1, 1'b0});
    va = 1'b1; da = 8'h5A;
    tick();
    va = 1'b0;
    tick();
    chk("start_low", tx_a, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_start", tx_a, 1'b1);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("abandoned", {tx_a, ba, ca}, {1'b1, 1'b0, 3'd0});

    // 6: one clock per bit, gapless
    do_reset();
    vb = 1'b1; db = 8'h80;
    tick();
    db = 8'h01;
    tick();
    vb = 1'b0;
    capture(1'b1, 20, cap);
    chk("cpb1_frames", cap, wave(8'h80, 8'h01, 2, 1));
    chk("cpb1_busy_e20", bb, 1'b1);
    tick();
    chk("cpb1_busy_e21", {tx_b, bb}, {1'b1, 1'b0});

    // Random traffic against a frame-level model
    do_reset();
    q = {};
    act = 1'b0;
    t = 0;
    cur = '0;
    pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) pct = (c / 500) % 3 == 0 ? 50 : (c / 500) % 3 == 1 ? 8 : 95;
      va = $urandom_range(0, 99) < pct;
      da = 8'($urandom);
      acc = va && q.size() < D;
      tick();
      if ((!act || t == 10 * CPB - 1) && q.size() > 0) begin
        cur = q.pop_front();
        act = 1'b1;
        t = 0;
      end else if (act && t == 10 * CPB - 1) begin
        act = 1'b0;
      end else if (act) begin
        t++;
      end
      if (acc) q.push_back(da);
      fr = frame(cur);
      exp_txd = act ? fr[t / CPB] : 1'b1;
      chk($sformatf("rand_c%0d", c), {tx_a, ra, ba, ca},
          {exp_txd, 1'(q.size() < D), 1'(act || q.size() != 0), 3'(q.size())});
    end
    va = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
